// File: rtl/saradc_11b_dig_lfsr_gen_pkg.sv
// Shared constants, tap table and single-step helper for the SAR dither LFSR.
package saradc_dig_lfsr_pkg;

  localparam int unsigned LFSR_WMIN = 4;
  localparam int unsigned LFSR_WMAX = 16;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_RECOVER,
    ACT_ADVANCE
  } lfsr_act_e;

  // Maximal-length Fibonacci masks; bit k-1 set for polynomial term x^k.
  function automatic logic [LFSR_WMAX-1:0] lfsr_taps(input int unsigned width);
    logic [LFSR_WMAX-1:0] m;
    case (width)
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Bits above the active width are don't-care; callers truncate the result.
  function automatic logic [LFSR_WMAX-1:0] lfsr_step(input logic [LFSR_WMAX-1:0] state,
                                                     input logic [LFSR_WMAX-1:0] mask);
    return {state[LFSR_WMAX-2:0], ^(state & mask)};
  endfunction

endpackage

// File: rtl/saradc_11b_dig_lfsr_gen_if.sv
// Control/status bundle between the dither logic and the LFSR generator.
interface saradc_11b_dig_lfsr_gen_if #(
  parameter int unsigned WIDTH = 10
);
  logic             enable_i;
  logic             seed_load_i;
  logic [WIDTH-1:0] seed_i;
  logic [WIDTH-1:0] val_o;
  logic             wrap_o;
  logic             lockup_o;

  modport master (
    output enable_i, seed_load_i, seed_i,
    input  val_o, wrap_o, lockup_o
  );

  modport slave (
    input  enable_i, seed_load_i, seed_i,
    output val_o, wrap_o, lockup_o
  );
endinterface

// File: rtl/saradc_11b_dig_lfsr_gen_adv.sv
// Combinational STEPS-fold unroll of the Fibonacci LFSR step.
module saradc_dig_lfsr_adv
  import saradc_dig_lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned STEPS = 1
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_state
);

  localparam logic [LFSR_WMAX-1:0] TAP_MASK = lfsr_taps(WIDTH);

  always_comb begin
    o_state = i_state;
    for (int unsigned i = 0; i < STEPS; i++) begin
      o_state = WIDTH'(lfsr_step(LFSR_WMAX'(o_state), TAP_MASK));
    end
  end

endmodule

// File: rtl/saradc_11b_dig_lfsr_gen.sv
// LFSR dither/calibration generator: seed load, multi-step advance,
// zero-state lockup recovery and sequence-wrap pulse.
module saradc_11b_dig_lfsr_gen
  import saradc_dig_lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned STEPS = 1
) (
  input logic                       clk,
  input logic                       nres,
  saradc_11b_dig_lfsr_gen_if.slave  bus
);

  if (WIDTH < LFSR_WMIN || WIDTH > LFSR_WMAX) begin : g_bad_width
    $fatal(1, "saradc_11b_dig_lfsr_gen: WIDTH out of range 4..16");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $fatal(1, "saradc_11b_dig_lfsr_gen: STEPS out of range 1..WIDTH");
  end

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_ref;
  logic             r_wrap;
  logic             r_lockup;

  logic [WIDTH-1:0] w_adv;
  logic [WIDTH-1:0] w_load_val;
  logic             w_seed_zero;
  lfsr_act_e        w_act;

  saradc_dig_lfsr_adv #(
    .WIDTH (WIDTH),
    .STEPS (STEPS)
  ) u_adv (
    .i_state (r_state),
    .o_state (w_adv)
  );

  // A zero seed would lock the register, so it is replaced by all-ones and flagged.
  always_comb begin
    w_seed_zero = (bus.seed_i == '0);
    w_load_val  = w_seed_zero ? '1 : bus.seed_i;
    w_act       = ACT_HOLD;
    if (bus.seed_load_i)      w_act = ACT_LOAD;
    else if (r_state == '0)   w_act = ACT_RECOVER;
    else if (bus.enable_i)    w_act = ACT_ADVANCE;
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_state  <= '1;
      r_ref    <= '1;
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      case (w_act)
        ACT_LOAD: begin
          r_state  <= w_load_val;
          r_ref    <= w_load_val;
          r_lockup <= w_seed_zero;
        end
        ACT_RECOVER: begin
          r_state  <= '1;
          r_lockup <= 1'b1;
        end
        ACT_ADVANCE: begin
          r_state <= w_adv;
          r_wrap  <= (w_adv == r_ref);
        end
        default: ;
      endcase
    end
  end

  assign bus.val_o    = r_state;
  assign bus.wrap_o   = r_wrap;
  assign bus.lockup_o = r_lockup;

endmodule

// File: tb/tb_saradc_11b_dig_lfsr_gen.sv
// Scoreboard bench for the LFSR generator: three instances (10b/1 step,
// 10b/2 steps, 4b/1 step) checked against an independent bit-level model.
module tb_saradc_11b_dig_lfsr_gen;

  typedef struct packed {
    logic [15:0] val;
    logic        wrap;
    logic        lock;
  } exp_t;

  logic clk  = 1'b0;
  logic nres = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  saradc_11b_dig_lfsr_gen_if #(.WIDTH(10)) if_a ();
  saradc_11b_dig_lfsr_gen_if #(.WIDTH(10)) if_b ();
  saradc_11b_dig_lfsr_gen_if #(.WIDTH(4))  if_c ();

  saradc_11b_dig_lfsr_gen #(.WIDTH(10), .STEPS(1)) dut_a (.clk(clk), .nres(nres), .bus(if_a));
  saradc_11b_dig_lfsr_gen #(.WIDTH(10), .STEPS(2)) dut_b (.clk(clk), .nres(nres), .bus(if_b));
  saradc_11b_dig_lfsr_gen #(.WIDTH(4),  .STEPS(1)) dut_c (.clk(clk), .nres(nres), .bus(if_c));

  // x^10+x^7+1 and x^4+x^3+1, written out bitwise
  function automatic logic [9:0] m10(input logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction
  function automatic logic [3:0] m4(input logic [3:0] v);
    return {v[2:0], v[3] ^ v[2]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic en, input logic ld, input logic [9:0] sd);
    if_a.enable_i = en; if_a.seed_load_i = ld; if_a.seed_i = sd;
  endtask
  task automatic drive_b(input logic en, input logic ld, input logic [9:0] sd);
    if_b.enable_i = en; if_b.seed_load_i = ld; if_b.seed_i = sd;
  endtask
  task automatic drive_c(input logic en, input logic ld, input logic [3:0] sd);
    if_c.enable_i = en; if_c.seed_load_i = ld; if_c.seed_i = sd;
  endtask

  task automatic do_reset();
    drive_a(0, 0, '0); drive_b(0, 0, '0); drive_c(0, 0, '0);
    nres = 1'b0;
    tick(); tick();
    nres = 1'b1;
  endtask

  task automatic test_reset();
    exp_t g;
    do_reset();
    g = {16'(if_a.val_o), if_a.wrap_o, if_a.lockup_o};
    n_cmp++;
    if (g !== {16'h03FF, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_a: got val=%h wrap=%b lock=%b, want 3ff 0 0", g.val, g.wrap, g.lock);
    end
    g = {16'(if_b.val_o), if_b.wrap_o, if_b.lockup_o};
    n_cmp++;
    if (g !== {16'h03FF, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_b: got val=%h wrap=%b lock=%b, want 3ff 0 0", g.val, g.wrap, g.lock);
    end
    g = {16'(if_c.val_o), if_c.wrap_o, if_c.lockup_o};
    n_cmp++;
    if (g !== {16'h000F, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_c: got val=%h wrap=%b lock=%b, want f 0 0", g.val, g.wrap, g.lock);
    end
  endtask

  task automatic test_basic_steps();
    logic [9:0] ev;
    exp_t e, g;
    logic [9:0] fixed_exp[3];
    fixed_exp[0] = 10'h3FE; fixed_exp[1] = 10'h3FC; fixed_exp[2] = 10'h3F8;
    do_reset();
    ev = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      drive_a(1, 0, '0);
      ev = m10(ev);
      sb.push_back('{val: 16'(ev), wrap: 1'b0, lock: 1'b0});
      tick();
      e = sb.pop_front();
      g = {16'(if_a.val_o), if_a.wrap_o, if_a.lockup_o};
      n_cmp++;
      if (g !== e || if_a.val_o !== fixed_exp[i]) begin
        n_err++;
        $display("FAIL basic_step%0d: got val=%h wrap=%b lock=%b, want val=%h wrap=%b lock=%b",
                 i, g.val, g.wrap, g.lock, fixed_exp[i], e.wrap, e.lock);
      end
    end
    drive_a(0, 0, '0);
  endtask

  task automatic test_full_period();
    logic [1023:0] seen;
    int dups, wraps, missing;
    logic [9:0] ev, hold_v;
    exp_t e, g;
    do_reset();
    seen = '0; dups = 0; wraps = 0; missing = 0;
    ev = 10'h3FF;
    for (int i = 0; i < 1023; i++) begin
      if (i == 500) begin
        drive_a(0, 0, '0);
        hold_v = ev;
        for (int h = 0; h < 5; h++) begin
          sb.push_back('{val: 16'(hold_v), wrap: 1'b0, lock: 1'b0});
          tick();
          e = sb.pop_front();
          g = {16'(if_a.val_o), if_a.wrap_o, if_a.lockup_o};
          n_cmp++;
          if (g !== e) begin
            n_err++;
            $display("FAIL hold%0d: got val=%h wrap=%b, want val=%h wrap=0", h, g.val, g.wrap, e.val);
          end
        end
      end
      drive_a(1, 0, '0);
      ev = m10(ev);
      sb.push_back('{val: 16'(ev), wrap: (ev == 10'h3FF), lock: 1'b0});
      tick();
      e = sb.pop_front();
      g = {16'(if_a.val_o), if_a.wrap_o, if_a.lockup_o};
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL period_step%0d: got val=%h wrap=%b lock=%b, want val=%h wrap=%b lock=%b",
                 i, g.val, g.wrap, g.lock, e.val, e.wrap, e.lock);
      end
      if (seen[if_a.val_o]) dups++;
      seen[if_a.val_o] = 1'b1;
      if (if_a.wrap_o) wraps++;
    end
    drive_a(0, 0, '0);
    for (int v = 1; v < 1024; v++) if (!seen[v]) missing++;
    n_cmp++;
    if (dups != 0 || missing != 0 || seen[0]) begin
      n_err++;
      $display("FAIL period_coverage: dups=%0d missing=%0d zero_seen=%b, want 0 0 0", dups, missing, seen[0]);
    end
    n_cmp++;
    if (wraps != 1 || if_a.val_o !== 10'h3FF) begin
      n_err++;
      $display("FAIL period_wrap: wraps=%0d final=%h, want 1 and 3ff", wraps, if_a.val_o);
    end
  endtask

  task automatic test_steps2();
    int wraps;
    logic [9:0] ev;
    exp_t e, g;
    do_reset();
    wraps = 0;
    ev = 10'h3FF;
    for (int i = 0; i < 1023; i++) begin
      drive_b(1, 0, '0);
      ev = m10(m10(ev));
      sb.push_back('{val: 16'(ev), wrap: (ev == 10'h3FF), lock: 1'b0});
      tick();
      e = sb.pop_front();
      g = {16'(if_b.val_o), if_b.wrap_o, if_b.lockup_o};
      if (i == 0) begin
        n_cmp++;
        if (if_b.val_o !== 10'h3FC) begin
          n_err++; $display("FAIL steps2_first: got val=%h, want 3fc", if_b.val_o);
        end
      end
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL steps2_step%0d: got val=%h wrap=%b, want val=%h wrap=%b", i, g.val, g.wrap, e.val, e.wrap);
      end
      if (if_b.wrap_o) wraps++;
    end
    drive_b(0, 0, '0);
    n_cmp++;
    if (wraps != 1) begin
      n_err++; $display("FAIL steps2_wraps: got %0d, want 1", wraps);
    end
  endtask

  task automatic test_seed_load();
    int wraps;
    logic [9:0] ev;
    exp_t e, g;
    do_reset();
    wraps = 0;
    drive_a(1, 1, 10'h001);
    sb.push_back('{val: 16'h0001, wrap: 1'b0, lock: 1'b0});
    tick();
    e = sb.pop_front();
    g = {16'(if_a.val_o), if_a.wrap_o, if_a.lockup_o};
    n_cmp++;
    if (g !== e) begin
      n_err++; $display("FAIL seed_load: got val=%h wrap=%b lock=%b, want 001 0 0", g.val, g.wrap, g.lock);
    end
    ev = 10'h001;
    for (int i = 0; i < 1023; i++) begin
      drive_a(1, 0, '0);
      ev = m10(ev);
      sb.push_back('{val: 16'(ev), wrap: (ev == 10'h001), lock: 1'b0});
      tick();
      e = sb.pop_front();
      g = {16'(if_a.val_o), if_a.wrap_o, if_a.lockup_o};
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL seed_step%0d: got val=%h wrap=%b, want val=%h wrap=%b", i, g.val, g.wrap, e.val, e.wrap);
      end
      if (if_a.wrap_o) wraps++;
    end
    drive_a(0, 0, '0);
    n_cmp++;
    if (wraps != 1) begin
      n_err++; $display("FAIL seed_wraps: got %0d, want 1", wraps);
    end
  endtask

  task automatic test_seed_zero();
    logic [9:0] ev;
    exp_t e, g;
    drive_a(0, 1, 10'h000);
    sb.push_back('{val: 16'h03FF, wrap: 1'b0, lock: 1'b1});
    tick();
    e = sb.pop_front();
    g = {16'(if_a.val_o), if_a.wrap_o, if_a.lockup_o};
    n_cmp++;
    if (g !== e) begin
      n_err++; $display("FAIL seed_zero: got val=%h wrap=%b lock=%b, want 3ff 0 1", g.val, g.wrap, g.lock);
    end
    ev = 10'h3FF;
    for (int i = 0; i < 20; i++) begin
      drive_a(1, 0, '0);
      ev = m10(ev);
      sb.push_back('{val: 16'(ev), wrap: (ev == 10'h3FF), lock: 1'b1});
      tick();
      e = sb.pop_front();
      g = {16'(if_a.val_o), if_a.wrap_o, if_a.lockup_o};
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL lock_hold%0d: got val=%h lock=%b, want val=%h lock=1", i, g.val, g.lock, e.val);
      end
    end
    drive_a(1, 1, 10'h155);
    sb.push_back('{val: 16'h0155, wrap: 1'b0, lock: 1'b0});
    tick();
    e = sb.pop_front();
    g = {16'(if_a.val_o), if_a.wrap_o, if_a.lockup_o};
    n_cmp++;
    if (g !== e) begin
      n_err++; $display("FAIL lock_clear: got val=%h wrap=%b lock=%b, want 155 0 0", g.val, g.wrap, g.lock);
    end
    drive_a(0, 0, '0);
  endtask

  task automatic test_w4_and_async_reset();
    int first_w, second_w;
    logic [3:0] ev;
    exp_t e, g;
    do_reset();
    first_w = -1; second_w = -1;
    ev = 4'hF;
    for (int i = 0; i < 30; i++) begin
      drive_c(1, 0, '0);
      ev = m4(ev);
      sb.push_back('{val: 16'(ev), wrap: (ev == 4'hF), lock: 1'b0});
      tick();
      e = sb.pop_front();
      g = {16'(if_c.val_o), if_c.wrap_o, if_c.lockup_o};
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL w4_step%0d: got val=%h wrap=%b, want val=%h wrap=%b", i, g.val, g.wrap, e.val, e.wrap);
      end
      if (if_c.wrap_o) begin
        if (first_w < 0) first_w = i; else if (second_w < 0) second_w = i;
      end
    end
    n_cmp++;
    if (first_w != 14 || second_w - first_w != 15) begin
      n_err++; $display("FAIL w4_period: first=%0d second=%0d, want 14 and 29", first_w, second_w);
    end
    // Set lockup, run to a wrap, then pull reset between edges
    drive_c(0, 1, 4'h0);
    tick();
    ev = 4'hF;
    for (int i = 0; i < 15; i++) begin
      drive_c(1, 0, '0);
      ev = m4(ev);
      sb.push_back('{val: 16'(ev), wrap: (ev == 4'hF), lock: 1'b1});
      tick();
      e = sb.pop_front();
      g = {16'(if_c.val_o), if_c.wrap_o, if_c.lockup_o};
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL w4_lock_step%0d: got val=%h wrap=%b lock=%b, want val=%h wrap=%b lock=1",
                 i, g.val, g.wrap, g.lock, e.val, e.wrap);
      end
    end
    drive_c(0, 0, '0);
    #2 nres = 1'b0;
    #1;
    g = {16'(if_c.val_o), if_c.wrap_o, if_c.lockup_o};
    n_cmp++;
    if (g !== {16'h000F, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL async_reset_wrap: got val=%h wrap=%b lock=%b, want f 0 0", g.val, g.wrap, g.lock);
    end
    @(posedge clk); #1 nres = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_c(1, 0, '0);
      tick();
    end
    drive_c(0, 0, '0);
    #3 nres = 1'b0;
    #1;
    g = {16'(if_c.val_o), if_c.wrap_o, if_c.lockup_o};
    n_cmp++;
    if (g !== {16'h000F, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL async_reset_mid: got val=%h wrap=%b lock=%b, want f 0 0", g.val, g.wrap, g.lock);
    end
    @(posedge clk); #1 nres = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_steps();
    test_full_period();
    test_steps2();
    test_seed_load();
    test_seed_zero();
    test_w4_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
